// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built from one full-adder cell and
// a carry flip-flop. Operands are captured on an accepted start and summed
// LSB first, one bit per clock, with a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             carry;
  logic [CW-1:0]    bit_cnt;

  logic             s_bit;
  logic             next_carry;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // The single full-adder cell working on the current LSBs and stored carry.
  assign s_bit      = a_sh[0] ^ b_sh[0] ^ carry;
  assign next_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign res_next   = {s_bit, res_sh};
  assign last_bit   = (bit_cnt == CW'(WIDTH - 1));

  // Control FSM and datapath: load on accept, shift one bit per RUN cycle,
  // publish the result and flags on the MSB edge. The edge leaving DONE also
  // accepts a new request, so held start sustains one operation every
  // WIDTH+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= sub ? ~b : b;
            carry   <= sub ? 1'b1 : cin;
            bit_cnt <= '0;
            res_sh  <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_next[WIDTH-1:1];
          carry   <= next_carry;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            sum      <= res_next;
            cout     <= next_carry;
            overflow <= carry ^ next_carry;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven and scoreboard-checked bench for serial_adder
// with WIDTH=8, covering reset, add/sub flags, handshake and mid-run reset.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int tests;
  int failed;
  int cycle;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  typedef struct {
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           acc;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[5];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .cin(cin),
    .sub(sub),
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout),
    .overflow(overflow)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure accept-to-done latency.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent arithmetic model returning {overflow, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W-1:0] bsel;
    logic         c;
    logic [W:0]   full;
    logic [W-1:0] low;
    bsel = msub ? ~mb : mb;
    c    = msub ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, bsel} + (W+1)'(c);
    low  = {1'b0, ma[W-2:0]} + {1'b0, bsel[W-2:0]} + W'(c);
    return {low[W-1] ^ full[W], full[W], full[W-1:0]};
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      checkOutput("busy_and_done_exclusive", 64'(busy), 64'(0));
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 64'(1), 64'(0));
      end else begin
        sb_t e;
        e = sbq.pop_front();
        checkOutput("sum", 64'(sum), 64'(e.es));
        checkOutput("cout", 64'(cout), 64'(e.ec));
        checkOutput("overflow", 64'(overflow), 64'(e.eo));
        checkOutput("latency", 64'(cycle - e.acc), 64'(W));
      end
    end
  end

  // Drive one request from IDLE and queue its expected result.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tcin, input logic tsub,
                               input logic [W-1:0] es, input logic ec, input logic eo);
    sb_t e;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk);
    #1;
    e.es = es; e.ec = ec; e.eo = eo; e.acc = cycle;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for all queued operations to complete.
  task automatic waitDrain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      checkOutput("drain_timeout", 64'(sbq.size()), 64'(0));
      sbq.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int   acc0;
    logic [W+1:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    tests = 0; failed = 0; cycle = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, sub: 1'b0, es: 8'h8D, ec: 1'b0, eo: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, es: 8'h00, ec: 1'b1, eo: 1'b0};
    vecs[2] = '{a: 8'h0F, b: 8'h00, cin: 1'b1, sub: 1'b0, es: 8'h10, ec: 1'b0, eo: 1'b0};
    vecs[3] = '{a: 8'h10, b: 8'h20, cin: 1'b1, sub: 1'b1, es: 8'hF0, ec: 1'b0, eo: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, cin: 1'b0, sub: 1'b1, es: 8'h7F, ec: 1'b1, eo: 1'b1};

    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_sum", 64'(sum), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                    vecs[i].es, vecs[i].ec, vecs[i].eo);
      waitDrain();
    end

    // Randomised vectors against the model.
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
      m = model(ra, rb, rc, rs);
      applyStimulus(ra, rb, rc, rs, m[W-1:0], m[W], m[W+1]);
      waitDrain();
    end

    // Asynchronous reset between edges with start held high.
    @(posedge clk);
    #3;
    start = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", 64'(busy), 64'(0));
    checkOutput("async_rst_done", 64'(done), 64'(0));
    checkOutput("async_rst_sum", 64'(sum), 64'(0));
    checkOutput("async_rst_cout", 64'(cout), 64'(0));
    checkOutput("async_rst_ovf", 64'(overflow), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_start_ignored", 64'(busy), 64'(0));
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_idle", 64'(busy), 64'(0));

    // Mid-run start pulse and operand changes must not disturb the result.
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (10) @(posedge clk);

    // Held start: back-to-back operations every W+1 cycles.
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    acc0 = cycle;
    for (int k = 0; k < 3; k++) begin
      sb_t e;
      e.es = 8'h8D; e.ec = 1'b0; e.eo = 1'b1; e.acc = acc0 + k * (W + 1);
      sbq.push_back(e);
    end
    repeat (2 * (W + 1)) @(posedge clk);
    #1;
    checkOutput("third_accept_busy", 64'(busy), 64'(1));
    @(negedge clk);
    start = 1'b0;
    waitDrain();

    // Reset during bit 3 aborts the operation.
    @(negedge clk);
    a = 8'h77; b = 8'h11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_done", 64'(done), 64'(0));
    checkOutput("abort_sum", 64'(sum), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abort_no_restart", 64'(busy), 64'(0));
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
